// File: rtl/ping_pong_sequence_decoder_pkg.sv
// Shared definitions for the ping-pong sequence decoder: FSM states,
// direction constants and the default sample width.
package ping_pong_sequence_decoder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEED  = 2'd1,
        S_TRACK = 2'd2,
        S_FAULT = 2'd3
    } state_e;

endpackage

// File: rtl/ping_pong_sequence_decoder_step_classify.sv
// Classifies one observed step (in_value - prev) relative to the current
// direction into hold / same-direction / reversal / illegal.
module ping_pong_sequence_decoder_step_classify
    import ping_pong_sequence_decoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] in_value,
    input  logic             dir,
    output logic             hold,
    output logic             same,
    output logic             reverse,
    output logic             bad
);

    logic [WIDTH:0] w_delta;
    logic           w_up1;
    logic           w_dn1;

    // Signed difference in WIDTH+1 bits; only 0 and +/-1 are legal steps.
    always_comb begin
        w_delta = {1'b0, in_value} - {1'b0, prev};
        w_up1   = (w_delta == {{WIDTH{1'b0}}, 1'b1});
        w_dn1   = (w_delta == {(WIDTH+1){1'b1}});
        hold    = (w_delta == {(WIDTH+1){1'b0}});
        same    = (dir == DIR_UP) ? w_up1 : w_dn1;
        reverse = (dir == DIR_DOWN) ? w_up1 : w_dn1;
        bad     = !(hold || w_up1 || w_dn1);
    end

endmodule

// File: rtl/ping_pong_sequence_decoder.sv
// Decodes a ping-pong counter's sample stream: direction, learned turning
// points, bounce count, forced-flip pulses and a sticky illegal-step error.
module ping_pong_sequence_decoder
    import ping_pong_sequence_decoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_value,
    input  logic             relearn,
    output logic             dir_out,
    output logic             locked,
    output logic [WIDTH-1:0] turn_max,
    output logic [WIDTH-1:0] turn_min,
    output logic             max_vld,
    output logic             min_vld,
    output logic [CNT_W-1:0] bounce_cnt,
    output logic             flip_evt,
    output logic             err,
    output logic [WIDTH-1:0] err_value
);

    state_e           r_state;
    state_e           w_next_state;
    logic [WIDTH-1:0] r_prev;
    logic             r_dir;
    logic             r_locked;
    logic [WIDTH-1:0] r_turn_max;
    logic [WIDTH-1:0] r_turn_min;
    logic             r_max_vld;
    logic             r_min_vld;
    logic [CNT_W-1:0] r_bounce_cnt;
    logic             r_flip_evt;
    logic             r_err;
    logic [WIDTH-1:0] r_err_value;

    logic w_hold;
    logic w_same;
    logic w_reverse;
    logic w_bad;
    logic w_max_known;
    logic w_min_known;

    ping_pong_sequence_decoder_step_classify #(.WIDTH(WIDTH)) u_classify (
        .prev     (r_prev),
        .in_value (in_value),
        .dir      (r_dir),
        .hold     (w_hold),
        .same     (w_same),
        .reverse  (w_reverse),
        .bad      (w_bad)
    );

    // A same-cycle relearn must hide the old turning points from this sample.
    assign w_max_known = r_max_vld && !relearn;
    assign w_min_known = r_min_vld && !relearn;

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_next_state = S_SEED;
                else          w_next_state = S_IDLE;
            end
            S_SEED: begin
                if (in_valid && (w_same || w_reverse)) w_next_state = S_TRACK;
                else if (in_valid && w_bad)            w_next_state = S_FAULT;
                else                                   w_next_state = S_SEED;
            end
            S_TRACK: begin
                if (in_valid && w_bad) w_next_state = S_FAULT;
                else                   w_next_state = S_TRACK;
            end
            S_FAULT: w_next_state = S_FAULT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Datapath: sample history, learned bounds, counters and error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev       <= {WIDTH{1'b0}};
            r_dir        <= DIR_UP;
            r_locked     <= 1'b0;
            r_turn_max   <= {WIDTH{1'b0}};
            r_turn_min   <= {WIDTH{1'b0}};
            r_max_vld    <= 1'b0;
            r_min_vld    <= 1'b0;
            r_bounce_cnt <= {CNT_W{1'b0}};
            r_flip_evt   <= 1'b0;
            r_err        <= 1'b0;
            r_err_value  <= {WIDTH{1'b0}};
        end else begin
            r_flip_evt <= 1'b0;
            r_locked   <= (w_next_state == S_TRACK);
            if (r_state != S_FAULT && relearn) begin
                r_max_vld <= 1'b0;
                r_min_vld <= 1'b0;
            end
            if (in_valid) begin
                case (r_state)
                    S_IDLE: r_prev <= in_value;
                    S_SEED: begin
                        if (w_same || w_reverse) begin
                            r_prev <= in_value;
                            r_dir  <= r_dir ^ w_reverse;
                        end else if (w_bad) begin
                            r_err       <= 1'b1;
                            r_err_value <= in_value;
                        end
                    end
                    S_TRACK: begin
                        if (w_same) begin
                            r_prev <= in_value;
                        end else if (w_reverse) begin
                            r_prev <= in_value;
                            r_dir  <= !r_dir;
                            if (r_bounce_cnt != {CNT_W{1'b1}})
                                r_bounce_cnt <= r_bounce_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                            if (r_dir == DIR_UP) begin
                                if (!w_max_known) begin
                                    r_turn_max <= r_prev;
                                    r_max_vld  <= 1'b1;
                                end else if (r_prev != r_turn_max) begin
                                    r_flip_evt <= 1'b1;
                                end
                            end else begin
                                if (!w_min_known) begin
                                    r_turn_min <= r_prev;
                                    r_min_vld  <= 1'b1;
                                end else if (r_prev != r_turn_min) begin
                                    r_flip_evt <= 1'b1;
                                end
                            end
                        end else if (w_bad) begin
                            r_err       <= 1'b1;
                            r_err_value <= in_value;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dir_out    = r_dir;
    assign locked     = r_locked;
    assign turn_max   = r_turn_max;
    assign turn_min   = r_turn_min;
    assign max_vld    = r_max_vld;
    assign min_vld    = r_min_vld;
    assign bounce_cnt = r_bounce_cnt;
    assign flip_evt   = r_flip_evt;
    assign err        = r_err;
    assign err_value  = r_err_value;

endmodule
